// File: rtl/rr_record_axi_writer.sv
// rtl/rr_record_axi_writer.sv - packed record stream to AXI4 INCR bursts into a host ring buffer
module rr_record_axi_writer #(
  parameter int DATA_WIDTH = 512,
  parameter int ADDR_WIDTH = 64,
  parameter int ID_WIDTH   = 15,
  parameter int BURST_LEN  = 16,
  parameter int FIFO_DEPTH = 32,
  parameter int WB_ID      = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic [DATA_WIDTH-1:0]   in_data,
  output logic                    in_ready,
  input  logic                    cfg_enable,
  input  logic [ADDR_WIDTH-1:0]   cfg_base,
  input  logic [31:0]             cfg_size,
  input  logic [31:0]             cfg_rd_off,
  input  logic                    cfg_flush,
  output logic [31:0]             wr_off,
  output logic [63:0]             bytes_written,
  output logic                    busy,
  output logic                    awvalid,
  input  logic                    awready,
  output logic [ADDR_WIDTH-1:0]   awaddr,
  output logic [7:0]              awlen,
  output logic [2:0]              awsize,
  output logic [1:0]              awburst,
  output logic [ID_WIDTH-1:0]     awid,
  output logic                    wvalid,
  input  logic                    wready,
  output logic [DATA_WIDTH-1:0]   wdata,
  output logic [DATA_WIDTH/8-1:0] wstrb,
  output logic                    wlast,
  input  logic                    bvalid,
  output logic                    bready,
  input  logic [1:0]              bresp,
  input  logic [ID_WIDTH-1:0]     bid
);
  localparam int BPB    = DATA_WIDTH / 8;
  localparam int BPB_LG = $clog2(BPB);
  localparam int PW     = $clog2(FIFO_DEPTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ADDR = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  logic [1:0]            state;
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]         rd_ptr, wr_ptr;
  logic [PW:0]           fifo_count;
  logic                  push, pop, start;
  logic [8:0]            beat_cnt;
  logic [31:0]           burst_bytes, used, free, room_beats, n_beats, n_bytes, off_sum;
  logic                  burst_flush, flush_pending, err;
  logic [62:0]           bw_cnt;
  logic                  unused_bid;

  assign unused_bid    = ^bid;
  assign in_ready      = fifo_count != (PW+1)'(FIFO_DEPTH);
  assign push          = in_valid & in_ready;
  assign wvalid        = (state == S_DATA) && (fifo_count != '0);
  assign pop           = wvalid & wready;
  assign wdata         = wvalid ? mem[rd_ptr] : '0;
  assign wlast         = (state == S_DATA) && (beat_cnt == 9'd1);
  assign awvalid       = (state == S_ADDR);
  assign bready        = 1'b1;
  assign busy          = (state != S_IDLE) || (fifo_count != '0);
  assign bytes_written = {err, bw_cnt};
  assign off_sum       = wr_off + burst_bytes;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      fifo_count <= fifo_count + (PW+1)'(push) - (PW+1)'(pop);
    end
  end

  // One beat of the ring stays unused so a full ring is distinguishable from an empty one.
  always_comb begin
    used       = (wr_off >= cfg_rd_off) ? wr_off - cfg_rd_off : wr_off + cfg_size - cfg_rd_off;
    free       = cfg_size - used - 32'(BPB);
    room_beats = (cfg_size - wr_off) >> BPB_LG;
    n_beats    = 32'(BURST_LEN);
    if (32'(fifo_count) < n_beats) n_beats = 32'(fifo_count);
    if (room_beats < n_beats) n_beats = room_beats;
    n_bytes    = n_beats << BPB_LG;
    start      = (state == S_IDLE) && cfg_enable && (n_bytes <= free) &&
                 ((32'(fifo_count) >= 32'(BURST_LEN)) || (flush_pending && (fifo_count != '0)));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      awaddr        <= '0;
      awlen         <= '0;
      awsize        <= '0;
      awburst       <= '0;
      awid          <= '0;
      wstrb         <= '0;
      beat_cnt      <= '0;
      burst_bytes   <= '0;
      burst_flush   <= 1'b0;
      flush_pending <= 1'b0;
      wr_off        <= '0;
      bw_cnt        <= '0;
      err           <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          state       <= S_ADDR;
          awaddr      <= cfg_base + ADDR_WIDTH'(wr_off);
          awlen       <= 8'(n_beats - 32'd1);
          awsize      <= 3'(BPB_LG);
          awburst     <= 2'b01;
          awid        <= ID_WIDTH'(WB_ID);
          wstrb       <= '1;
          beat_cnt    <= 9'(n_beats);
          burst_bytes <= n_bytes;
          // A flush is satisfied only by a burst that drains everything queued at issue.
          burst_flush <= flush_pending && (32'(fifo_count) == n_beats);
        end
        S_ADDR: if (awready) state <= S_DATA;
        S_DATA: if (pop) begin
          beat_cnt <= beat_cnt - 9'd1;
          if (beat_cnt == 9'd1) state <= S_RESP;
        end
        default: if (bvalid) begin
          state  <= S_IDLE;
          wr_off <= (off_sum == cfg_size) ? 32'd0 : off_sum;
          bw_cnt <= bw_cnt + 63'(burst_bytes);
          if (bresp != 2'b00) err <= 1'b1;
          if (burst_flush) flush_pending <= 1'b0;
        end
      endcase
      if (cfg_flush) flush_pending <= (fifo_count != '0);
    end
  end
endmodule
